vram_writer: RTL and testbench
==============================

Name: vram_writer

Overview:
- Command-driven write port for VIDEORAM: game logic posts tile-write commands, and this block turns them into RAM write cycles.
- Sits between the game/control FSM in the CLK_PLL domain and the VIDEORAM write side (waddr/wdata/wen). VGA_RAM_Controller is the reader at the other end.
- Buffers commands in a small FIFO.
- Expands fill and row-fill commands into back-to-back single-word writes.

Parameters:
ADDR_W, 4, VIDEORAM address width; RAM holds 2^ADDR_W words
DATA_W, 6, tile payload width (colour/symbol code)
RAM_W, 8, VIDEORAM word width; payload is zero-extended to it
FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2)
ROW_LEN, 4, words per board row for FILL_ROW (power of 2, <=2^ADDR_W)

Ports:
CLK  in  1  clock (CLK_PLL)
RST  in  1  synchronous reset, active-high
CMD_VALID  in  1  command present
CMD_READY  out  1  FIFO can accept; equals !full
CMD_OP  in  2  00 WRITE, 01 FILL, 10 FILL_ROW, 11 reserved
CMD_ADDR  in  ADDR_W  target / row address
CMD_DATA  in  DATA_W  payload
RAM_WADDR  out  ADDR_W  VIDEORAM write address (registered)
RAM_WDATA  out  RAM_W  {zeros, payload} (registered)
RAM_WEN  out  1  write strobe, one word per cycle (registered)
BUSY  out  1  FIFO non-empty or a command executing
ERR  out  1  sticky: a reserved op was accepted

Behaviour:
- Reset state: RAM_WADDR=0, RAM_WDATA=0, RAM_WEN=0, ERR=0, BUSY=0, CMD_READY=1. FIFO is emptied and any in-progress command is aborted.
- Reset mid-fill: no RAM_WEN after the reset edge, and the fill does not resume.
- Accept rule: a command is pushed on a rising edge with CMD_VALID=1 and CMD_READY=1.
- A push is refused when full, even if a pop happens in the same cycle.
- Push into a non-full FIFO while simultaneously popping is legal; occupancy is unchanged.
- FSM states:
  - IDLE: FIFO empty, RAM_WEN=0.
  - EXEC: emitting writes.
- Pop/execute: when not executing and the FIFO is non-empty, pop the head and emit its first write on that edge.
- Latency: a command accepted at edge k into an empty idle block gives RAM_WEN=1 between edges k+1 and k+2.
- WRITE: one cycle. RAM_WADDR=CMD_ADDR, RAM_WDATA=CMD_DATA zero-extended.
- FILL: 2^ADDR_W consecutive cycles, addresses 0..2^ADDR_W-1 ascending, same data. CMD_ADDR is ignored.
- FILL_ROW:
  - base = CMD_ADDR with low log2(ROW_LEN) bits cleared.
  - ROW_LEN consecutive cycles, addresses base..base+ROW_LEN-1.
  - Never wraps past the row.
- Reserved op 11:
  - Popped and discarded; sets ERR (sticky until RST).
  - Emits no write and consumes one cycle with RAM_WEN=0.
- Back-to-back: if the FIFO is non-empty, the next command's first write occurs in the cycle after the previous command's last write, with no bubble.
- After the final write of the last command: RAM_WEN=0 next cycle. RAM_WADDR/RAM_WDATA hold their last values.
- BUSY=1 from the edge after acceptance until the edge where the last write's RAM_WEN is deasserted.
- Address counter is ADDR_W bits. The fill terminal count is all-ones; there is no overflow carry.
- Commands execute strictly in acceptance order.

Test Plan:
- Reset, then WRITE addr=5 data=0x2A at edge k:
  - RAM_WEN=1 exactly one cycle (edges k+1..k+2), RAM_WADDR=5, RAM_WDATA=0x2A.
  - BUSY then falls, ERR=0.
- FILL data=0x07:
  - 16 consecutive RAM_WEN cycles, addresses 0..15, RAM_WDATA=0x07 each.
  - No gaps; BUSY high throughout.
- FILL_ROW addr=6 data=0x11:
  - Exactly 4 writes to addresses 4,5,6,7 with data 0x11.
  - No write to 8.
- Hold CMD_VALID=1 with 6 WRITEs during a FILL:
  - CMD_READY drops after 4 are queued and reasserts after pops.
  - All 6 appear after the fill, in order, with no bubbles between them.
- CMD_OP=11 between two WRITEs:
  - ERR=1 and stays set.
  - One RAM_WEN=0 cycle between the two writes.
  - The second write is still performed.
- RST asserted at the 8th cycle of a FILL with 2 queued commands:
  - From the next edge RAM_WEN=0, BUSY=0, CMD_READY=1, ERR=0.
  - No further writes are emitted.

Source files
------------

// File: rtl/vram_writer.sv
// vram_writer: command FIFO feeding VIDEORAM writes.
// WRITE, FILL and FILL_ROW expand into one word per cycle.
module vram_writer #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 6,
  parameter int RAM_W      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int ROW_LEN    = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic [1:0]        CMD_OP,
  input  logic [ADDR_W-1:0] CMD_ADDR,
  input  logic [DATA_W-1:0] CMD_DATA,
  output logic [ADDR_W-1:0] RAM_WADDR,
  output logic [RAM_W-1:0]  RAM_WDATA,
  output logic              RAM_WEN,
  output logic              BUSY,
  output logic              ERR
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = 2 + ADDR_W + DATA_W;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EXEC = 1'b1;

  localparam logic [ADDR_W-1:0] ROW_MSK =
    ADDR_W'(ROW_LEN - 1);
  localparam logic [PW:0] FULL_CNT =
    (PW + 1)'(FIFO_DEPTH);

  logic [CW-1:0]     mem [FIFO_DEPTH];
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic [PW:0]       count;
  logic [0:0]        state;
  logic [ADDR_W-1:0] last;

  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              free;
  logic [1:0]        hd_op;
  logic [ADDR_W-1:0] hd_addr;
  logic [DATA_W-1:0] hd_data;
  logic [RAM_W-1:0]  hd_ext;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign push  = CMD_VALID && !full;

  // Free once the word on the bus is the command's last one.
  assign free = (state == S_IDLE) || (RAM_WADDR == last);
  assign pop  = free && !empty;

  assign {hd_op, hd_addr, hd_data} = mem[rptr];
  assign hd_ext = RAM_W'(hd_data);

  assign CMD_READY = !full;
  assign BUSY      = !empty || (state == S_EXEC);

  // FIFO storage; only written on an accepted push.
  always_ff @(posedge CLK) begin
    if (push) mem[wptr] <= {CMD_OP, CMD_ADDR, CMD_DATA};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Command execution: load on pop, then step the address.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      last      <= '0;
      RAM_WADDR <= '0;
      RAM_WDATA <= '0;
      RAM_WEN   <= 1'b0;
      ERR       <= 1'b0;
    end else if (pop) begin
      unique case (1'b1)
        (hd_op == 2'b00): begin
          state     <= S_EXEC;
          RAM_WEN   <= 1'b1;
          RAM_WADDR <= hd_addr;
          last      <= hd_addr;
          RAM_WDATA <= hd_ext;
        end
        (hd_op == 2'b01): begin
          state     <= S_EXEC;
          RAM_WEN   <= 1'b1;
          RAM_WADDR <= '0;
          last      <= '1;
          RAM_WDATA <= hd_ext;
        end
        (hd_op == 2'b10): begin
          state     <= S_EXEC;
          RAM_WEN   <= 1'b1;
          RAM_WADDR <= hd_addr & ~ROW_MSK;
          last      <= hd_addr | ROW_MSK;
          RAM_WDATA <= hd_ext;
        end
        default: begin
          state   <= S_IDLE;
          RAM_WEN <= 1'b0;
          ERR     <= 1'b1;
        end
      endcase
    end else if (free) begin
      state   <= S_IDLE;
      RAM_WEN <= 1'b0;
    end else begin
      RAM_WADDR <= RAM_WADDR + 1'b1;
    end
  end

endmodule

// File: tb/tb_vram_writer.sv
// tb_vram_writer: directed stimulus, queue model
// and write log checked every cycle.
module tb_vram_writer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_addr;
  logic [5:0] cmd_data;
  logic [3:0] ram_waddr;
  logic [7:0] ram_wdata;
  logic       ram_wen;
  logic       busy;
  logic       err;

  vram_writer dut (
    .CLK       (clk),
    .RST       (rst),
    .CMD_VALID (cmd_valid),
    .CMD_READY (cmd_ready),
    .CMD_OP    (cmd_op),
    .CMD_ADDR  (cmd_addr),
    .CMD_DATA  (cmd_data),
    .RAM_WADDR (ram_waddr),
    .RAM_WDATA (ram_wdata),
    .RAM_WEN   (ram_wen),
    .BUSY      (busy),
    .ERR       (err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d want %0d",
               nm, act, exp);
    end
  endtask

  // Model: queued commands, and the word stream of
  // the command currently executing.
  int         cq[$];
  int         cur[$];
  logic       m_wen  = 1'b0;
  logic [3:0] m_addr = '0;
  logic [7:0] m_data = '0;
  logic       m_err  = 1'b0;

  function automatic void expand(input int c);
    int op;
    int a;
    int d;
    op = (c >> 10) & 3;
    a  = (c >> 6) & 15;
    d  = c & 63;
    case (op)
      0: cur.push_back((a << 8) | d);
      1: for (int i = 0; i < 16; i++)
           cur.push_back((i << 8) | d);
      2: for (int i = 0; i < 4; i++)
           cur.push_back((((a / 4) * 4 + i) << 8) | d);
      default: cur.push_back(1 << 20);
    endcase
  endfunction

  always @(posedge clk) begin
    bit acc;
    int it;
    acc = cmd_valid && (cq.size() < 4);
    if (rst) begin
      cq.delete();
      cur.delete();
      m_wen  = 1'b0;
      m_addr = '0;
      m_data = '0;
      m_err  = 1'b0;
    end else begin
      if (cur.size() == 0 && cq.size() > 0)
        expand(cq.pop_front());
      if (cur.size() > 0) begin
        it = cur.pop_front();
        if ((it >> 20) != 0) begin
          m_wen = 1'b0;
          m_err = 1'b1;
        end else begin
          m_wen  = 1'b1;
          m_addr = 4'((it >> 8) & 15);
          m_data = 8'(it & 255);
        end
      end else begin
        m_wen = 1'b0;
      end
      if (acc)
        cq.push_back(int'({cmd_op, cmd_addr, cmd_data}));
    end
  end

  typedef struct {
    int a;
    int d;
    int c;
  } wr_t;

  wr_t wlog[$];
  int  cyc      = 0;
  bit  started  = 1'b0;
  bit  saw_full = 1'b0;

  // Per-cycle compare against the model, plus a write log.
  always @(negedge clk) begin
    if (started) begin
      cyc++;
      chk("wen", ram_wen, m_wen);
      chk("waddr", ram_waddr, m_addr);
      chk("wdata", ram_wdata, m_data);
      chk("busy", busy,
          int'(cq.size() > 0 || m_wen));
      chk("ready", cmd_ready, int'(cq.size() < 4));
      chk("err", err, m_err);
      if (ram_wen)
        wlog.push_back('{int'(ram_waddr),
                         int'(ram_wdata), cyc});
      if (!cmd_ready) saw_full = 1'b1;
    end
  end

  task automatic send(input logic [1:0] op,
                      input logic [3:0] a,
                      input logic [5:0] d);
    bit ok;
    ok        = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_data  = d;
    for (int i = 0; i < 200 && !ok; i++) begin
      ok = cmd_ready;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("send_accept", ok, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", busy, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_addr  = '0;
    cmd_data  = '0;
    repeat (3) @(negedge clk);
    rst     = 1'b0;
    started = 1'b1;

    chk("rst_wen", ram_wen, 0);
    chk("rst_waddr", ram_waddr, 0);
    chk("rst_wdata", ram_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_err", err, 0);

    // Single WRITE: latency and one-cycle strobe.
    send(2'b00, 4'd5, 6'h2A);
    chk("w_busy_k", busy, 1);
    chk("w_wen_k", ram_wen, 0);
    @(negedge clk);
    chk("w_wen", ram_wen, 1);
    chk("w_addr", ram_waddr, 5);
    chk("w_data", ram_wdata, 8'h2A);
    @(negedge clk);
    chk("w_wen_off", ram_wen, 0);
    chk("w_busy_off", busy, 0);
    chk("w_err", err, 0);
    chk("w_hold_addr", ram_waddr, 5);
    chk("w_count", wlog.size(), 1);

    // FILL: 16 gapless writes 0..15.
    base = wlog.size();
    send(2'b01, 4'd9, 6'h07);
    wait_idle();
    chk("fill_count", wlog.size() - base, 16);
    for (int i = 0; i < 16; i++) begin
      chk("fill_addr", wlog[base + i].a, i);
      chk("fill_data", wlog[base + i].d, 8'h07);
      chk("fill_cyc", wlog[base + i].c,
          wlog[base].c + i);
    end

    // FILL_ROW inside row 4..7.
    base = wlog.size();
    send(2'b10, 4'd6, 6'h11);
    wait_idle();
    chk("row_count", wlog.size() - base, 4);
    for (int i = 0; i < 4; i++) begin
      chk("row_addr", wlog[base + i].a, 4 + i);
      chk("row_data", wlog[base + i].d, 8'h11);
    end

    // Six WRITEs queued behind a FILL.
    saw_full = 1'b0;
    base = wlog.size();
    send(2'b01, 4'd0, 6'h03);
    for (int i = 0; i < 6; i++)
      send(2'b00, 4'(i + 1), 6'(8'h20 + i));
    wait_idle();
    chk("q_full_seen", saw_full, 1);
    chk("q_ready", cmd_ready, 1);
    chk("q_count", wlog.size() - base, 22);
    for (int j = 0; j < 6; j++) begin
      chk("q_addr", wlog[base + 16 + j].a, j + 1);
      chk("q_data", wlog[base + 16 + j].d, 8'h20 + j);
      chk("q_cyc", wlog[base + 16 + j].c,
          wlog[base].c + 16 + j);
    end

    // Reserved op between two WRITEs.
    base = wlog.size();
    send(2'b00, 4'd2, 6'h01);
    send(2'b11, 4'd0, 6'h00);
    send(2'b00, 4'd3, 6'h02);
    wait_idle();
    chk("rsv_count", wlog.size() - base, 2);
    chk("rsv_a0", wlog[base].a, 2);
    chk("rsv_a1", wlog[base + 1].a, 3);
    chk("rsv_d1", wlog[base + 1].d, 2);
    chk("rsv_gap", wlog[base + 1].c - wlog[base].c, 2);
    chk("rsv_err", err, 1);
    repeat (5) @(negedge clk);
    chk("rsv_err_sticky", err, 1);

    // Reset on the 8th FILL cycle with two queued.
    base = wlog.size();
    send(2'b01, 4'd0, 6'h05);
    send(2'b00, 4'd10, 6'h01);
    send(2'b00, 4'd11, 6'h02);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mr_wen", ram_wen, 0);
    chk("mr_busy", busy, 0);
    chk("mr_ready", cmd_ready, 1);
    chk("mr_err", err, 0);
    chk("mr_pre_count", wlog.size() - base, 8);
    base = wlog.size();
    repeat (30) @(negedge clk);
    chk("mr_no_writes", wlog.size() - base, 0);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
